// File: rtl/aes_encrypt_iter_pkg.sv
// Shared definitions for the iterative AES-128 encryptor.
// Holds the S-box, the round constants, the round count, the FSM state
// type and the helper functions used by the round datapath and key
// expansion. No ports: imported by aes_enc_round and aes_encrypt_iter.
package aes_encrypt_iter_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused: rounds are numbered 1..10.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    // Out-of-range round numbers map to 0 so an illegal counter value can
    // never index past the table.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r <= 4'd10) begin
            return RCON[r];
        end else begin
            return 8'h00;
        end
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One step of the AES-128 key expansion: RotWord, SubWord, Rcon, chain.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports:
//   state_in  [127:0] round input state (byte 0 in bits [127:120], column-major)
//   round_key [127:0] key added at the end of the round
//   is_final          1 = last round, MixColumns bypassed
//   state_out [127:0] round output state
module aes_enc_round
    import aes_encrypt_iter_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         is_final,
    output logic [127:0] state_out
);

    logic [7:0] sb_s [16];
    logic [7:0] sr_s [16];
    logic [7:0] mc_s [16];

    // SubBytes, ShiftRows, optional MixColumns and AddRoundKey.
    always_comb begin
        state_out = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sb_s[i] = sbox(state_in[127 - 8*i -: 8]);
        end
        // Byte index is 4*column + row; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[4*c + r] = sb_s[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (is_final) begin
                mc_s[4*c]     = sr_s[4*c];
                mc_s[4*c + 1] = sr_s[4*c + 1];
                mc_s[4*c + 2] = sr_s[4*c + 2];
                mc_s[4*c + 3] = sr_s[4*c + 3];
            end else begin
                mc_s[4*c]     = xtime(sr_s[4*c]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
                mc_s[4*c + 1] = sr_s[4*c] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
                mc_s[4*c + 2] = sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
                mc_s[4*c + 3] = xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = mc_s[i] ^ round_key[127 - 8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on
// the fly from the previous round key.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake for plain_text and key
//   plain_text, key [127:0] block and cipher key (byte 0 in bits [127:120])
//   out_valid/out_ready    output handshake for cipher_text
//   cipher_text [127:0]    result, forced to 0 while out_valid is low
//   busy                   high while a job is running or waiting to drain
module aes_encrypt_iter
    import aes_encrypt_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic         busy
);

    aes_fsm_e     fsm_r;
    logic [3:0]   round_r;
    logic [127:0] state_r;
    logic [127:0] key_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [127:0] cipher_text_r;

    logic [127:0] round_key_s;
    logic [127:0] round_out_s;
    logic         is_final_s;

    // Next round key and last-round flag for the round in flight.
    always_comb begin
        round_key_s = key_step(key_r, rcon(round_r));
        is_final_s  = (round_r == 4'(NUM_ROUNDS));
    end

    aes_enc_round u_round (
        .state_in  (state_r),
        .round_key (round_key_s),
        .is_final  (is_final_s),
        .state_out (round_out_s)
    );

    // Control FSM, round datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r         <= ST_IDLE;
            round_r       <= 4'd0;
            state_r       <= 128'h0;
            key_r         <= 128'h0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            cipher_text_r <= 128'h0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r    <= plain_text ^ key;
                        key_r      <= key;
                        round_r    <= 4'd1;
                        fsm_r      <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        fsm_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    state_r <= round_out_s;
                    key_r   <= round_key_s;
                    if (is_final_s) begin
                        round_r       <= 4'd0;
                        fsm_r         <= ST_DONE;
                        out_valid_r   <= 1'b1;
                        cipher_text_r <= round_out_s;
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_r         <= ST_IDLE;
                        out_valid_r   <= 1'b0;
                        cipher_text_r <= 128'h0;
                        busy_r        <= 1'b0;
                        in_ready_r    <= 1'b1;
                    end else begin
                        fsm_r <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    fsm_r         <= ST_IDLE;
                    round_r       <= 4'd0;
                    out_valid_r   <= 1'b0;
                    cipher_text_r <= 128'h0;
                    busy_r        <= 1'b0;
                    in_ready_r    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign cipher_text = cipher_text_r;

endmodule
